// File: rtl/cpu_test_pkg.sv
// Shared constants and state encoding for the hardware-test register dump path.
package cpu_test_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] CHECKSUM_SEED = 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StRead,
    StWait,
    StDone
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Valid/ready word stream from the dump engine to the test host.
interface reg_dump_reader_if;
  import cpu_test_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_reader_out_slot.sv
// Single-entry output holding register; payload is frozen while valid and not accepted.
module dump_out_slot
  import cpu_test_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  index_o,
  output logic              last_o,
  output logic              accept_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              last_q, last_d;

  assign accept_o = valid_q & ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    if (accept_o) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      index_d = index_i;
      last_d  = last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign index_o = index_q;
  assign last_o  = last_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Freezes the CPU, walks regfile addresses 0..REGNUM-1 and streams each word with an XOR checksum.
module reg_dump_reader
  import cpu_test_pkg::*;
#(
  parameter int unsigned REGNUM      = 8,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  output logic              cpu_hold,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  reg_dump_reader_if.master out_if
);

  localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(REGNUM - 1);
  localparam logic [3:0]       SettleInit = 4'(HOLD_CYCLES - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic              slot_load;
  logic              slot_accept;
  logic              slot_valid;
  logic [DATA_W-1:0] slot_data;
  logic [IDX_W-1:0]  slot_index;
  logic              slot_last;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    slot_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          addr_d  = '0;
          csum_d  = CHECKSUM_SEED;
          cnt_d   = SettleInit;
        end
      end
      // Gives an in-flight regfile write time to land before the first read.
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StRead;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRead: begin
        slot_load = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (slot_accept) begin
          csum_d = csum_q ^ slot_data;
          if (slot_last) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  dump_out_slot u_out_slot (
    .clk_i    (CLK),
    .rst_ni   (RSTn),
    .load_i   (slot_load),
    .data_i   (rd_data),
    .index_i  (addr_q),
    .last_i   (addr_q == LastIdx),
    .ready_i  (out_if.out_ready),
    .valid_o  (slot_valid),
    .data_o   (slot_data),
    .index_o  (slot_index),
    .last_o   (slot_last),
    .accept_o (slot_accept)
  );

  assign out_if.out_valid = slot_valid;
  assign out_if.out_data  = slot_data;
  assign out_if.out_index = slot_index;
  assign out_if.out_last  = slot_last;

  assign busy     = (state_q != StIdle);
  assign cpu_hold = busy;
  assign done     = (state_q == StDone);
  assign rd_addr  = addr_q;
  assign checksum = csum_q;

endmodule
